// File: rtl/serdesphy_pwr_seq.sv
// serdesphy_pwr_seq: CSR-driven PHY power sequencer (bring-up on phy_en, drained or emergency teardown)
// Ports: clk/rst_n_in clock and async active-low reset; por_complete, phy_en, supply_warn, drain_ack control inputs;
// drain_req datapath drain request; analog_iso_n, digital_reset_n, analog_reset_n PHY controls (0 = isolated/reset);
// phy_active PHY up; pd_busy teardown in progress; pd_done teardown-complete pulse; drain_timeout sticky drain timeout.
module serdesphy_pwr_seq #(
  parameter int STEP_CYCLES          = 12,
  parameter int DIG_HOLD_CYCLES      = 24,
  parameter int DRAIN_TIMEOUT_CYCLES = 96,
  parameter int TMR_W                = 8
) (
  input  logic clk,
  input  logic rst_n_in,
  input  logic por_complete,
  input  logic phy_en,
  input  logic supply_warn,
  input  logic drain_ack,
  output logic drain_req,
  output logic analog_iso_n,
  output logic digital_reset_n,
  output logic analog_reset_n,
  output logic phy_active,
  output logic pd_busy,
  output logic pd_done,
  output logic drain_timeout
);
  typedef enum logic [2:0] {OFF, UP_DIG, UP_ANA, ON, DRAIN, DN_ANA, DN_DIG, DN_ISO} state_t;
  localparam logic [TMR_W-1:0] STEP  = TMR_W'(STEP_CYCLES);
  localparam logic [TMR_W-1:0] HOLD  = TMR_W'(DIG_HOLD_CYCLES);
  localparam logic [TMR_W-1:0] DRAIN_TMO = TMR_W'(DRAIN_TIMEOUT_CYCLES);
  state_t           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic iso_q, dig_q, ana_q, act_q, req_q, done_q, tmo_q;
  logic go, abort, emerg, tz, to_dn;
  assign go    = phy_en & por_complete & ~supply_warn;
  assign abort = ~go;
  assign emerg = supply_warn | ~por_complete;
  assign tz    = tmr_q == '0;
  // Every path into DN_ANA shares the same entry actions, so it is decoded once here.
  always_comb begin
    to_dn = 1'b0;
    case (state_q)
      OFF, DN_ANA, DN_DIG, DN_ISO: to_dn = 1'b0;
      UP_DIG, UP_ANA:              to_dn = abort;
      ON:                          to_dn = emerg;
      DRAIN:                       to_dn = emerg | drain_ack | tz;
      default:                     to_dn = 1'b1;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= OFF;
      tmr_q   <= '0;
      iso_q   <= 1'b0;
      dig_q   <= 1'b0;
      ana_q   <= 1'b0;
      act_q   <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      tmr_q  <= tz ? tmr_q : tmr_q - 1'b1;
      case (state_q)
        OFF: if (go) begin
          state_q <= UP_DIG;
          iso_q   <= 1'b1;
          tmo_q   <= 1'b0;
          tmr_q   <= STEP;
        end
        UP_DIG: if (!abort && tz) begin
          state_q <= UP_ANA;
          dig_q   <= 1'b1;
          tmr_q   <= STEP;
        end
        UP_ANA: if (!abort && tz) begin
          state_q <= ON;
          ana_q   <= 1'b1;
          act_q   <= 1'b1;
        end
        ON: if (!emerg && !phy_en) begin
          state_q <= DRAIN;
          req_q   <= 1'b1;
          tmr_q   <= DRAIN_TMO;
        end
        DRAIN: if (!emerg && !drain_ack && tz) tmo_q <= 1'b1;
        DN_ANA: if (tz) begin
          state_q <= DN_DIG;
          dig_q   <= 1'b0;
          tmr_q   <= HOLD;
        end
        DN_DIG: if (tz) begin
          state_q <= DN_ISO;
          iso_q   <= 1'b0;
          tmr_q   <= STEP;
        end
        DN_ISO: if (tz) begin
          state_q <= OFF;
          done_q  <= 1'b1;
        end
        default: ;
      endcase
      if (to_dn) begin
        state_q <= DN_ANA;
        ana_q   <= 1'b0;
        act_q   <= 1'b0;
        req_q   <= 1'b0;
        tmr_q   <= STEP;
      end
    end
  end
  assign drain_req       = req_q;
  assign analog_iso_n    = iso_q;
  assign digital_reset_n = dig_q;
  assign analog_reset_n  = ana_q;
  assign phy_active      = act_q;
  assign pd_busy         = state_q inside {DRAIN, DN_ANA, DN_DIG, DN_ISO};
  assign pd_done         = done_q;
  assign drain_timeout   = tmo_q;
endmodule
